// File: rtl/corr_sequencer.sv
// Correlation pass sequencer: walks lag x sample indices for the MAC sumator and
// strobes the peak-search solver once per lag, delayed to match the sumator pipeline.
// Latency: CLEAR one cycle after start is sampled. RUN lasts CORR*SAMPLES cycles. DRAIN lasts PIPE_LAT cycles. DONE lasts one cycle.
// Backpressure: none; once started the pass free-runs until it completes or is aborted.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous reset, active low
//   start       begin a pass (only looked at in IDLE)
//   abort       synchronous cancel from any non-IDLE state
//   lag         current lag index
//   sample_idx  current sample index within the lag
//   acc_clr     sumator loads instead of adding (first sample of each lag)
//   acc_ena     sumator accumulate enable
//   slv_clr     solver clear, one cycle per pass
//   slv_ena     solver data-valid, one cycle per lag
//   busy        high from CLEAR through DONE
//   done        one-cycle pulse when a pass completes
module corr_sequencer #(
  parameter int CORR     = 4980,
  parameter int SAMPLES  = 64,
  parameter int PIPE_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [12:0] lag,
  output logic [7:0]  sample_idx,
  output logic        acc_clr,
  output logic        acc_ena,
  output logic        slv_clr,
  output logic        slv_ena,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [12:0] LAG_LAST   = 13'(CORR - 1);
  localparam logic [7:0]  SMP_LAST   = 8'(SAMPLES - 1);
  localparam logic [3:0]  DRAIN_LAST = 4'(PIPE_LAT - 1);

  state_t              r_state;
  logic [12:0]         r_lag;
  logic [7:0]          r_sidx;
  logic [3:0]          r_dcnt;
  logic                r_acc_clr;
  logic                r_acc_ena;
  logic                r_slv_clr;
  logic                r_busy;
  logic                r_done;
  logic [PIPE_LAT-1:0] r_dl;

  logic                w_last_smp;
  logic [PIPE_LAT-1:0] w_dl_next;

  // A lag-complete token is generated on the cycle the last sample of a lag
  // is being accumulated; it emerges from the delay line PIPE_LAT cycles later.
  assign w_last_smp = (r_state == S_RUN) && (r_sidx == SMP_LAST);

  always_comb begin
    w_dl_next    = r_dl << 1;
    w_dl_next[0] = w_last_smp;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_lag     <= 13'd0;
      r_sidx    <= 8'd0;
      r_dcnt    <= 4'd0;
      r_acc_clr <= 1'b0;
      r_acc_ena <= 1'b0;
      r_slv_clr <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dl      <= '0;
    end else if (abort && (r_state != S_IDLE)) begin
      // Cancel drops everything, including tokens still in flight, so the
      // solver sees no further enables from the aborted pass.
      r_state   <= S_IDLE;
      r_lag     <= 13'd0;
      r_sidx    <= 8'd0;
      r_dcnt    <= 4'd0;
      r_acc_clr <= 1'b0;
      r_acc_ena <= 1'b0;
      r_slv_clr <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dl      <= '0;
    end else begin
      r_dl <= w_dl_next;
      case (r_state)
        S_IDLE: begin
          // abort outranks start even while idle: a coincident pair does not launch.
          if (start && !abort) begin
            r_state   <= S_CLEAR;
            r_slv_clr <= 1'b1;
            r_busy    <= 1'b1;
            r_lag     <= 13'd0;
            r_sidx    <= 8'd0;
          end
        end
        S_CLEAR: begin
          r_state   <= S_RUN;
          r_slv_clr <= 1'b0;
          r_acc_ena <= 1'b1;
          r_acc_clr <= 1'b1;
        end
        S_RUN: begin
          if (r_sidx == SMP_LAST) begin
            if (r_lag == LAG_LAST) begin
              // Final sample: counters hold their last values through DRAIN/DONE.
              r_state   <= S_DRAIN;
              r_acc_ena <= 1'b0;
              r_acc_clr <= 1'b0;
              r_dcnt    <= 4'd0;
            end else begin
              r_lag     <= r_lag + 13'd1;
              r_sidx    <= 8'd0;
              r_acc_clr <= 1'b1;
            end
          end else begin
            r_sidx    <= r_sidx + 8'd1;
            r_acc_clr <= 1'b0;
          end
        end
        S_DRAIN: begin
          // Wait out the pipeline so the last lag's slv_ena lands in the final DRAIN cycle.
          if (r_dcnt == DRAIN_LAST) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_dcnt <= r_dcnt + 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_lag   <= 13'd0;
          r_sidx  <= 8'd0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign lag        = r_lag;
  assign sample_idx = r_sidx;
  assign acc_clr    = r_acc_clr;
  assign acc_ena    = r_acc_ena;
  assign slv_clr    = r_slv_clr;
  assign slv_ena    = r_dl[PIPE_LAT-1];
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
